// File: rtl/ts_pkg.sv
// Shared constants and types for the MPEG-2 TS continuity-counter monitor.
package ts_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h47;
    localparam int unsigned PID_W = 13;
    localparam int unsigned CC_W = 4;
    localparam logic [PID_W-1:0] NULL_PID = 13'h1FFF;

    localparam logic [1:0] AFC_RSVD = 2'b00;
    localparam logic [1:0] AFC_PAYLOAD = 2'b01;
    localparam logic [1:0] AFC_ADAPT_ONLY = 2'b10;
    localparam logic [1:0] AFC_BOTH = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StH1,
        StH2,
        StH3,
        StLookup
    } ts_state_e;

endpackage

// File: rtl/ts_cc_monitor_array_if.sv
// Packed per-channel byte-stream bus feeding the CC monitor array.
interface ts_cc_monitor_array_if #(
    parameter int unsigned N_CH = 4
);

    logic [N_CH-1:0]   valid;
    logic [N_CH-1:0]   sync;
    logic [8*N_CH-1:0] data;

    modport master (output valid, output sync, output data);
    modport slave (input valid, input sync, input data);

endinterface

// File: rtl/ts_cc_channel.sv
// One channel: TS header parser, per-PID last-CC table, CC checker and
// saturating error counter.
module ts_cc_channel
    import ts_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned N_PID = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic             sync,
    input  logic [7:0]       data,
    input  logic             en_reset_counter,
    output logic [CNT_W-1:0] error_count,
    output logic             error_pulse,
    output logic             table_full
);

    localparam int unsigned IdxW = $clog2(N_PID);

    ts_state_e        state_q, state_d;
    logic             tei_q, tei_d;
    logic [PID_W-1:0] pid_q, pid_d;
    logic [1:0]       afc_q, afc_d;
    logic [CC_W-1:0]  cc_q, cc_d;

    logic [N_PID-1:0] slot_valid_q;
    logic [N_PID-1:0] slot_dup_q;
    logic [PID_W-1:0] slot_pid_q [N_PID];
    logic [CC_W-1:0]  slot_cc_q [N_PID];

    logic [CNT_W-1:0] cnt_q;
    logic             pulse_q;
    logic             full_q;

    logic             start;
    logic             unused_hdr_bits;

    // PUSI/priority and scrambling bits are carried but not interpreted
    assign unused_hdr_bits = ^data[6:5];
    assign start = valid && sync && (data == SYNC_BYTE);

    always_comb begin
        state_d = state_q;
        tei_d   = tei_q;
        pid_d   = pid_q;
        afc_d   = afc_q;
        cc_d    = cc_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StH1;
            end
            StH1: begin
                if (start) begin
                    state_d = StH1;
                end else if (valid) begin
                    tei_d        = data[7];
                    pid_d[12:8]  = data[4:0];
                    state_d      = StH2;
                end
            end
            StH2: begin
                if (start) begin
                    state_d = StH1;
                end else if (valid) begin
                    pid_d[7:0] = data;
                    state_d    = StH3;
                end
            end
            StH3: begin
                if (start) begin
                    state_d = StH1;
                end else if (valid) begin
                    afc_d   = data[5:4];
                    cc_d    = data[3:0];
                    state_d = StLookup;
                end
            end
            StLookup: begin
                // A new sync byte arriving while the lookup runs is not lost
                state_d = start ? StH1 : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    logic [N_PID-1:0] hit_vec;
    logic             hit;
    logic [IdxW-1:0]  hit_idx;
    logic             free_found;
    logic [IdxW-1:0]  free_idx;

    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < N_PID; i++) begin
            hit_vec[i] = slot_valid_q[i] && (slot_pid_q[i] == pid_q);
            if (hit_vec[i]) begin
                hit     = 1'b1;
                hit_idx = IdxW'(i);
            end
        end
        // Descending scan so the lowest free index wins
        for (int i = N_PID - 1; i >= 0; i--) begin
            if (!slot_valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
        end
    end

    logic            lookup, skip;
    logic [CC_W-1:0] last_cc, next_cc;
    logic            last_dup;
    logic            cc_err, do_store, set_dup, do_alloc, drop;

    assign lookup   = (state_q == StLookup);
    assign skip     = tei_q || (pid_q == NULL_PID) || (afc_q == AFC_RSVD);
    assign last_cc  = slot_cc_q[hit_idx];
    assign last_dup = slot_dup_q[hit_idx];
    assign next_cc  = last_cc + CC_W'(1);

    always_comb begin
        cc_err   = 1'b0;
        do_store = 1'b0;
        set_dup  = 1'b0;
        do_alloc = 1'b0;
        drop     = 1'b0;
        if (lookup && !skip) begin
            if (hit) begin
                if (afc_q == AFC_ADAPT_ONLY) begin
                    cc_err = (cc_q != last_cc);
                end else if (cc_q == next_cc) begin
                    do_store = 1'b1;
                end else if ((cc_q == last_cc) && !last_dup) begin
                    set_dup = 1'b1;
                end else begin
                    cc_err   = 1'b1;
                    do_store = 1'b1;
                end
            end else if (free_found) begin
                do_alloc = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            tei_q        <= 1'b0;
            pid_q        <= '0;
            afc_q        <= '0;
            cc_q         <= '0;
            slot_valid_q <= '0;
            slot_dup_q   <= '0;
            slot_pid_q   <= '{default: '0};
            slot_cc_q    <= '{default: '0};
            cnt_q        <= '0;
            pulse_q      <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            tei_q   <= tei_d;
            pid_q   <= pid_d;
            afc_q   <= afc_d;
            cc_q    <= cc_d;
            if (do_store) begin
                slot_cc_q[hit_idx]  <= cc_q;
                slot_dup_q[hit_idx] <= 1'b0;
            end
            if (set_dup) slot_dup_q[hit_idx] <= 1'b1;
            if (do_alloc) begin
                slot_valid_q[free_idx] <= 1'b1;
                slot_pid_q[free_idx]   <= pid_q;
                slot_cc_q[free_idx]    <= cc_q;
                slot_dup_q[free_idx]   <= 1'b0;
            end
            pulse_q <= cc_err;
            if (en_reset_counter) begin
                cnt_q <= '0;
            end else if (cc_err && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (en_reset_counter) begin
                full_q <= 1'b0;
            end else if (drop) begin
                full_q <= 1'b1;
            end
        end
    end

    assign error_count = cnt_q;
    assign error_pulse = pulse_q;
    assign table_full  = full_q;

endmodule

// File: rtl/ts_cc_monitor_array.sv
// Multi-channel TS continuity-counter monitor: one independent checker per
// input byte lane.
module ts_cc_monitor_array
    import ts_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned N_PID = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    ts_cc_monitor_array_if.slave    bus,
    input  logic                    en_reset_counter,
    output logic [N_CH*CNT_W-1:0]   error_count,
    output logic [N_CH-1:0]         error_pulse,
    output logic [N_CH-1:0]         table_full
);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        ts_cc_channel #(
            .CNT_W (CNT_W),
            .N_PID (N_PID)
        ) u_ch (
            .clk              (clk),
            .reset            (reset),
            .valid            (bus.valid[gi]),
            .sync             (bus.sync[gi]),
            .data             (bus.data[gi*8 +: 8]),
            .en_reset_counter (en_reset_counter),
            .error_count      (error_count[gi*CNT_W +: CNT_W]),
            .error_pulse      (error_pulse[gi]),
            .table_full       (table_full[gi])
        );
    end

endmodule

// File: tb/tb_ts_cc_monitor_array.sv
// Bench for ts_cc_monitor_array: directed vector table, corner-case sequences
// and randomized traffic against a PID-keyed reference model.
module tb_ts_cc_monitor_array;

    localparam int N_CH    = 4;
    localparam int CNT_W   = 8;
    localparam int N_PID   = 8;
    localparam int CNT_MAX = 255;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  en_reset_counter;
    logic [N_CH*CNT_W-1:0] error_count;
    logic [N_CH-1:0]       error_pulse;
    logic [N_CH-1:0]       table_full;

    always #5 clk = ~clk;

    ts_cc_monitor_array_if #(.N_CH(N_CH)) bus ();

    ts_cc_monitor_array #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W),
        .N_PID (N_PID)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .en_reset_counter (en_reset_counter),
        .error_count      (error_count),
        .error_pulse      (error_pulse),
        .table_full       (table_full)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int c);
        return 32'(error_count[c*CNT_W +: CNT_W]);
    endfunction

    function automatic logic [31:0] hdr(input logic tei, input logic [12:0] pid,
                                        input logic [1:0] afc, input logic [3:0] cc);
        return {8'h47, tei, 2'b00, pid[12:8], pid[7:0], 2'b00, afc, cc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N_CH-1:0] mask, input logic [N_CH-1:0] sy,
                         input logic [N_CH-1:0][7:0] bytes);
        for (int c = 0; c < N_CH; c++) begin
            bus.valid[c]       = mask[c];
            bus.sync[c]        = sy[c] & mask[c];
            bus.data[c*8 +: 8] = bytes[c];
        end
        step();
        bus.valid = '0;
        bus.sync  = '0;
    endtask

    // Returns one cycle after the last header byte, i.e. during the lookup cycle
    task automatic send_hdrs(input logic [N_CH-1:0] mask, input logic [N_CH-1:0][31:0] h);
        logic [N_CH-1:0][7:0] bytes;
        for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < N_CH; c++) bytes[c] = h[c][31-8*b -: 8];
            drive(mask, (b == 0) ? mask : '0, bytes);
        end
    endtask

    task automatic send(input logic [N_CH-1:0] mask, input logic tei, input logic [12:0] pid,
                        input logic [1:0] afc, input logic [3:0] cc);
        logic [N_CH-1:0][31:0] h;
        for (int c = 0; c < N_CH; c++) h[c] = hdr(tei, pid, afc, cc);
        send_hdrs(mask, h);
    endtask

    // Reference model: last CC and duplicate flag per (channel, PID)
    int m_last[int];
    bit m_dup[int];
    int m_used[N_CH];
    bit m_full[N_CH];
    int m_cnt[N_CH];

    task automatic model_reset();
        m_last.delete();
        m_dup.delete();
        for (int c = 0; c < N_CH; c++) begin
            m_used[c] = 0;
            m_full[c] = 0;
            m_cnt[c]  = 0;
        end
    endtask

    function automatic bit model_pkt(input int ch, input bit tei, input int pid,
                                     input int afc, input int cc);
        int key = ch * 8192 + pid;
        if (tei || pid == 'h1FFF || afc == 0) return 0;
        if (!m_last.exists(key)) begin
            if (m_used[ch] < N_PID) begin
                m_last[key] = cc;
                m_dup[key]  = 0;
                m_used[ch]++;
            end else begin
                m_full[ch] = 1;
            end
            return 0;
        end
        if (afc == 2) return cc != m_last[key];
        if (cc == (m_last[key] + 1) % 16) begin
            m_last[key] = cc;
            m_dup[key]  = 0;
            return 0;
        end
        if (cc == m_last[key] && !m_dup[key]) begin
            m_dup[key] = 1;
            return 0;
        end
        m_last[key] = cc;
        m_dup[key]  = 0;
        return 1;
    endfunction

    typedef struct {
        int ch;
        bit tei;
        int pid;
        int afc;
        int cc;
        bit exp_pulse;
        int exp_cnt;
    } vec_t;

    vec_t vecs[17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc;
        reset            = 1'b1;
        en_reset_counter = 1'b0;
        bus.valid        = '0;
        bus.sync         = '0;
        bus.data         = '0;
        step();
        step();
        check("reset error_count", 32'(error_count), 0);
        check("reset error_pulse", 32'(error_pulse), 0);
        check("reset table_full", 32'(table_full), 0);
        reset = 1'b0;
        step();

        vecs[0]  = '{0, 0, 'h100, 1, 0, 0, 0};
        vecs[1]  = '{0, 0, 'h100, 1, 1, 0, 0};
        vecs[2]  = '{0, 0, 'h100, 1, 2, 0, 0};
        vecs[3]  = '{0, 0, 'h100, 1, 3, 0, 0};
        vecs[4]  = '{0, 0, 'h101, 3, 15, 0, 0};
        vecs[5]  = '{0, 0, 'h101, 3, 0, 0, 0};
        vecs[6]  = '{1, 0, 'h100, 1, 5, 0, 0};
        vecs[7]  = '{1, 0, 'h100, 1, 5, 0, 0};
        vecs[8]  = '{1, 0, 'h100, 1, 6, 0, 0};
        vecs[9]  = '{1, 0, 'h100, 1, 6, 0, 0};
        vecs[10] = '{1, 0, 'h100, 1, 6, 1, 1};
        vecs[11] = '{2, 0, 'h200, 1, 3, 0, 0};
        vecs[12] = '{2, 0, 'h200, 2, 3, 0, 0};
        vecs[13] = '{2, 0, 'h200, 2, 4, 1, 1};
        vecs[14] = '{2, 0, 'h200, 1, 4, 0, 1};
        vecs[15] = '{2, 0, 'h200, 0, 9, 0, 1};
        vecs[16] = '{2, 0, 'h200, 1, 5, 0, 1};

        foreach (vecs[i]) begin
            logic [N_CH-1:0] m;
            m = '0;
            m[vecs[i].ch] = 1'b1;
            send(m, vecs[i].tei, 13'(vecs[i].pid), 2'(vecs[i].afc), 4'(vecs[i].cc));
            step();
            check($sformatf("vec%0d pulse", i), 32'(error_pulse),
                  vecs[i].exp_pulse ? 32'(m) : 0);
            check($sformatf("vec%0d count", i), cnt_of(vecs[i].ch), 32'(vecs[i].exp_cnt));
        end
        check("idle ch3 count", cnt_of(3), 0);

        // Fill ch3's table, then overflow it
        for (int i = 0; i < 8; i++) begin
            send(4'b1000, 0, 13'('h10 + i), 1, 0);
            step();
        end
        check("table not yet full", 32'(table_full), 0);
        send(4'b1000, 0, 'h18, 1, 0);
        step();
        check("table_full after 9th pid", 32'(table_full), 32'b1000);
        send(4'b1000, 0, 'h18, 1, 5);
        step();
        check("untracked pid no pulse", 32'(error_pulse), 0);
        send(4'b1000, 0, 'h10, 1, 1);
        step();
        check("tracked pid still ok", 32'(error_pulse), 0);
        for (int k = 0; k < 4; k++) begin
            send(4'b1000, 0, 'h1FFF, 1, 4'($urandom_range(15)));
            step();
            check("null pid no pulse", 32'(error_pulse), 0);
            send(4'b1000, 1, 'h10, 1, 4'($urandom_range(15)));
            step();
            check("tei no pulse", 32'(error_pulse), 0);
        end
        send(4'b1000, 0, 'h10, 1, 2);
        step();
        check("tei left table untouched", cnt_of(3), 0);

        // Saturation on ch0
        send(4'b0001, 0, 'h300, 1, 0);
        step();
        lc = 0;
        for (int i = 0; i < 300; i++) begin
            lc = (lc + 5) % 16;
            send(4'b0001, 0, 'h300, 1, 4'(lc));
            step();
        end
        check("saturated count", cnt_of(0), CNT_MAX);
        check("saturated still pulses", 32'(error_pulse), 1);

        // Counter clear coinciding with an error
        lc = (lc + 5) % 16;
        send(4'b0001, 0, 'h300, 1, 4'(lc));
        en_reset_counter = 1'b1;
        step();
        en_reset_counter = 1'b0;
        check("clear keeps pulse", 32'(error_pulse), 1);
        check("clear beats increment", cnt_of(0), 0);
        check("clear zeroes ch1", cnt_of(1), 0);
        check("clear drops table_full", 32'(table_full), 0);
        lc = (lc + 1) % 16;
        send(4'b0001, 0, 'h300, 1, 4'(lc));
        step();
        check("table kept after clear", 32'(error_pulse) | cnt_of(0), 0);

        // Simultaneous errors on every channel
        reset = 1'b1;
        step();
        reset = 1'b0;
        send(4'b1111, 0, 'h400, 1, 0);
        step();
        send(4'b1111, 0, 'h400, 1, 7);
        step();
        check("all-channel pulse", 32'(error_pulse), 32'hF);
        for (int c = 0; c < N_CH; c++) check($sformatf("all-channel count%0d", c), cnt_of(c), 1);

        // Sync restart at H2 on ch1: new header must be the one checked
        drive(4'b0010, 4'b0010, {4{8'h47}});
        drive(4'b0010, 4'b0000, {4{8'h04}});
        send(4'b0010, 0, 'h400, 1, 3);
        step();
        check("restart pulse", 32'(error_pulse), 32'b0010);
        check("restart count", cnt_of(1), 2);

        // Reset in the middle of a header on ch0
        drive(4'b0001, 4'b0001, {4{8'h47}});
        drive(4'b0001, 4'b0000, {4{8'h04}});
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset count", 32'(error_count), 0);
        check("midreset pulse", 32'(error_pulse), 0);
        check("midreset full", 32'(table_full), 0);
        drive(4'b0001, 4'b0000, {4{8'h00}});
        drive(4'b0001, 4'b0000, {4{8'h19}});
        step();
        check("partial header discarded", 32'(error_pulse), 0);
        send(4'b0001, 0, 'h400, 1, 9);
        step();
        check("table empty after reset", 32'(error_pulse), 0);
        send(4'b0001, 0, 'h400, 1, 3);
        step();
        check("post-reset error counted", cnt_of(0), 1);

        // Randomized traffic against the model
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        for (int it = 0; it < 300; it++) begin
            logic [N_CH-1:0]       mask;
            logic [N_CH-1:0][31:0] h;
            logic [N_CH-1:0]       exp_p;
            bit                    en;
            bit                    tei_a[N_CH];
            int                    pid_a[N_CH], afc_a[N_CH], cc_a[N_CH];
            for (int c = 0; c < N_CH; c++) begin
                int key, r;
                mask[c]  = ($urandom_range(3) != 0);
                tei_a[c] = ($urandom_range(15) == 0);
                pid_a[c] = ($urandom_range(12) == 12) ? 'h1FFF : 'h20 + $urandom_range(11);
                afc_a[c] = $urandom_range(3);
                key      = c * 8192 + pid_a[c];
                r        = $urandom_range(9);
                if (m_last.exists(key) && r < 5)      cc_a[c] = (m_last[key] + 1) % 16;
                else if (m_last.exists(key) && r < 7) cc_a[c] = m_last[key];
                else                                  cc_a[c] = $urandom_range(15);
                h[c] = hdr(tei_a[c], 13'(pid_a[c]), 2'(afc_a[c]), 4'(cc_a[c]));
            end
            send_hdrs(mask, h);
            en = ($urandom_range(24) == 0);
            en_reset_counter = en;
            step();
            en_reset_counter = 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                exp_p[c] = mask[c] ? model_pkt(c, tei_a[c], pid_a[c], afc_a[c], cc_a[c]) : 1'b0;
                if (exp_p[c] && m_cnt[c] < CNT_MAX) m_cnt[c]++;
                if (en) begin
                    m_cnt[c]  = 0;
                    m_full[c] = 0;
                end
            end
            check($sformatf("rand%0d pulse", it), 32'(error_pulse), 32'(exp_p));
            for (int c = 0; c < N_CH; c++) begin
                check($sformatf("rand%0d count%0d", it, c), cnt_of(c), 32'(m_cnt[c]));
                check($sformatf("rand%0d full%0d", it, c), 32'(table_full[c]), 32'(m_full[c]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
